// File: rtl/ex_reg.sv
// EX/MEM pipeline register: latches the ALU result with the ID control fields.
// It turns a signed ADD/SUB overflow into an OVERFLOW exception and counts those events.
module ex_reg #(
  parameter int WORD_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OFCNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_W-1:0]     alu_out,
  input  logic                  alu_of,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  int_detect,
  input  logic [WORD_W-1:0]     id_pc,
  input  logic                  id_en,
  input  logic                  id_br_flag,
  input  logic [1:0]            id_mem_op,
  input  logic [WORD_W-1:0]     id_mem_wr_data,
  input  logic [1:0]            id_ctrl_op,
  input  logic [REG_ADDR_W-1:0] id_dst_addr,
  input  logic                  id_gpr_we_,
  input  logic [2:0]            id_exp_code,
  output logic [WORD_W-1:0]     ex_pc,
  output logic                  ex_en,
  output logic                  ex_br_flag,
  output logic [1:0]            ex_mem_op,
  output logic [WORD_W-1:0]     ex_mem_wr_data,
  output logic [1:0]            ex_ctrl_op,
  output logic [REG_ADDR_W-1:0] ex_dst_addr,
  output logic                  ex_gpr_we_,
  output logic [2:0]            ex_exp_code,
  output logic [WORD_W-1:0]     ex_out,
  output logic [OFCNT_W-1:0]    ex_of_cnt
);

  localparam logic [2:0] EXP_OVERFLOW = 3'd3;

  logic [WORD_W-1:0]     pc_q, pc_d;
  logic                  en_q, en_d;
  logic                  br_flag_q, br_flag_d;
  logic [1:0]            mem_op_q, mem_op_d;
  logic [WORD_W-1:0]     mem_wr_data_q, mem_wr_data_d;
  logic [1:0]            ctrl_op_q, ctrl_op_d;
  logic [REG_ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic                  gpr_we_q, gpr_we_d;
  logic [2:0]            exp_code_q, exp_code_d;
  logic [WORD_W-1:0]     out_q, out_d;
  logic [OFCNT_W-1:0]    of_cnt_q, of_cnt_d;

  // Next-state selection: stall, then bubble, then overflow capture, then pass-through.
  always_comb begin
    pc_d          = pc_q;
    en_d          = en_q;
    br_flag_d     = br_flag_q;
    mem_op_d      = mem_op_q;
    mem_wr_data_d = mem_wr_data_q;
    ctrl_op_d     = ctrl_op_q;
    dst_addr_d    = dst_addr_q;
    gpr_we_d      = gpr_we_q;
    exp_code_d    = exp_code_q;
    out_d         = out_q;
    of_cnt_d      = of_cnt_q;
    if (stall) begin
      of_cnt_d = of_cnt_q;
    end else if (flush || int_detect) begin
      pc_d          = id_pc;
      en_d          = 1'b0;
      br_flag_d     = 1'b0;
      mem_op_d      = 2'b00;
      mem_wr_data_d = {WORD_W{1'b0}};
      ctrl_op_d     = 2'b00;
      dst_addr_d    = {REG_ADDR_W{1'b0}};
      gpr_we_d      = 1'b1;
      exp_code_d    = 3'd0;
      out_d         = {WORD_W{1'b0}};
    end else if (alu_of && id_en) begin
      // The faulting instruction keeps its pc but loses every side effect.
      pc_d          = id_pc;
      en_d          = 1'b1;
      br_flag_d     = 1'b0;
      mem_op_d      = 2'b00;
      mem_wr_data_d = {WORD_W{1'b0}};
      ctrl_op_d     = 2'b00;
      dst_addr_d    = {REG_ADDR_W{1'b0}};
      gpr_we_d      = 1'b1;
      exp_code_d    = EXP_OVERFLOW;
      out_d         = {WORD_W{1'b0}};
      if (&of_cnt_q) begin
        of_cnt_d = of_cnt_q;
      end else begin
        of_cnt_d = of_cnt_q + {{(OFCNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      pc_d          = id_pc;
      en_d          = id_en;
      br_flag_d     = id_br_flag;
      mem_op_d      = id_mem_op;
      mem_wr_data_d = id_mem_wr_data;
      ctrl_op_d     = id_ctrl_op;
      dst_addr_d    = id_dst_addr;
      gpr_we_d      = id_gpr_we_;
      exp_code_d    = id_exp_code;
      out_d         = alu_out;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= {WORD_W{1'b0}};
      en_q          <= 1'b0;
      br_flag_q     <= 1'b0;
      mem_op_q      <= 2'b00;
      mem_wr_data_q <= {WORD_W{1'b0}};
      ctrl_op_q     <= 2'b00;
      dst_addr_q    <= {REG_ADDR_W{1'b0}};
      gpr_we_q      <= 1'b1;
      exp_code_q    <= 3'd0;
      out_q         <= {WORD_W{1'b0}};
      of_cnt_q      <= {OFCNT_W{1'b0}};
    end else begin
      pc_q          <= pc_d;
      en_q          <= en_d;
      br_flag_q     <= br_flag_d;
      mem_op_q      <= mem_op_d;
      mem_wr_data_q <= mem_wr_data_d;
      ctrl_op_q     <= ctrl_op_d;
      dst_addr_q    <= dst_addr_d;
      gpr_we_q      <= gpr_we_d;
      exp_code_q    <= exp_code_d;
      out_q         <= out_d;
      of_cnt_q      <= of_cnt_d;
    end
  end

  assign ex_pc          = pc_q;
  assign ex_en          = en_q;
  assign ex_br_flag     = br_flag_q;
  assign ex_mem_op      = mem_op_q;
  assign ex_mem_wr_data = mem_wr_data_q;
  assign ex_ctrl_op     = ctrl_op_q;
  assign ex_dst_addr    = dst_addr_q;
  assign ex_gpr_we_     = gpr_we_q;
  assign ex_exp_code    = exp_code_q;
  assign ex_out         = out_q;
  assign ex_of_cnt      = of_cnt_q;

endmodule
